// File: rtl/viterbi_pkg.sv
// Shared Viterbi datapath types and default widths (used by the SIPO chunker and the symbol packer).
package viterbi_pkg;

    localparam int SYM_W  = 2;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_OUTPUT
    } pack_state_t;

endpackage

// File: rtl/symbol_packer_if.sv
// Symbol-in / word-out handshake bundle for the symbol packer.
interface symbol_packer_if #(
    parameter int SIZE_DATA_IN  = viterbi_pkg::SYM_W,
    parameter int SIZE_DATA_OUT = viterbi_pkg::WORD_W
);
    localparam int CNT_W = $clog2(SIZE_DATA_OUT / SIZE_DATA_IN);

    logic                     i_start;
    logic                     i_valid;
    logic [SIZE_DATA_IN-1:0]  i_data;
    logic                     o_ready;
    logic [SIZE_DATA_OUT-1:0] o_data;
    logic                     o_valid;
    logic                     i_ready;
    logic                     o_done;
    logic [CNT_W-1:0]         o_count;

    modport slave (
        input  i_start, i_valid, i_data, i_ready,
        output o_ready, o_data, o_valid, o_done, o_count
    );

    modport master (
        output i_start, i_valid, i_data, i_ready,
        input  o_ready, o_data, o_valid, o_done, o_count
    );

endinterface

// File: rtl/symbol_packer.sv
// Packs MSB-first symbols into one word per frame slot, gated by the level i_start.
// o_valid the cycle after the last symbol accept; input stalls (o_ready=0) while a word is offered.
module symbol_packer
    import viterbi_pkg::*;
#(
    parameter int SIZE_DATA_IN  = SYM_W,
    parameter int SIZE_DATA_OUT = WORD_W
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    symbol_packer_if.slave bus
);

    localparam int NUM_SYM = SIZE_DATA_OUT / SIZE_DATA_IN;
    localparam int CNT_W   = $clog2(NUM_SYM);
    localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(NUM_SYM - 1);

    if (((SIZE_DATA_OUT % SIZE_DATA_IN) != 0) || (NUM_SYM < 2)) begin : g_param_check
        $error("symbol_packer: SIZE_DATA_OUT must be a multiple of SIZE_DATA_IN holding at least two symbols");
    end

    pack_state_t              state;
    logic [SIZE_DATA_OUT-1:0] shreg;
    logic [SIZE_DATA_OUT-1:0] shreg_nxt;
    logic [SIZE_DATA_OUT-1:0] data_q;
    logic [CNT_W-1:0]         count;
    logic                     valid_q;
    logic                     done_q;
    logic                     collect;

    assign collect   = (state == ST_COLLECT);
    assign shreg_nxt = {shreg[SIZE_DATA_OUT-SIZE_DATA_IN-1:0], bus.i_data};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            data_q  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state <= ST_COLLECT;
                        count <= '0;
                        shreg <= '0;
                    end
                end
                ST_COLLECT: begin
                    // Frame drop wins over a same-cycle symbol: the partial word is thrown away.
                    if (!bus.i_start) begin
                        state <= ST_IDLE;
                        count <= '0;
                        shreg <= '0;
                    end else if (bus.i_valid) begin
                        shreg <= shreg_nxt;
                        if (count == LAST_SYM) begin
                            data_q  <= shreg_nxt;
                            valid_q <= 1'b1;
                            count   <= '0;
                            state   <= ST_OUTPUT;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= bus.i_start ? ST_COLLECT : ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    count   <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready = collect;
    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
    assign bus.o_done  = done_q;
    assign bus.o_count = count;

endmodule

// File: tb/tb_symbol_packer.sv
// Randomized and directed bench for symbol_packer against a queue-based word model.
module tb_symbol_packer;

    localparam int SIN  = 2;
    localparam int SOUT = 16;
    localparam int NSYM = SOUT / SIN;
    localparam int CW   = $clog2(NSYM);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Symbols accepted into the word currently being built, in arrival order.
    logic [SIN-1:0] frame[$];

    symbol_packer_if #(.SIZE_DATA_IN(SIN), .SIZE_DATA_OUT(SOUT)) bus ();

    symbol_packer #(.SIZE_DATA_IN(SIN), .SIZE_DATA_OUT(SOUT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // First symbol is the most significant digit in base 2**SIN.
    function automatic logic [SOUT-1:0] model_word();
        int unsigned w = 0;
        foreach (frame[k]) w = w * (2 ** SIN) + 32'(frame[k]);
        return w[SOUT-1:0];
    endfunction

    // Entered at a negedge; returns at the negedge following the accepting edge.
    task automatic push_sym(input logic [SIN-1:0] s);
        int n = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = s;
        while (bus.o_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL push_timeout: o_ready=%b after %0d cycles, required 1", bus.o_ready, n);
        end
        @(negedge clk);
        frame.push_back(s);
        bus.i_valid = 1'b0;
        bus.i_data  = SIN'($urandom);
    endtask

    task automatic test_reset();
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: rdy/vld/done=%b required 000", {bus.o_ready, bus.o_valid, bus.o_done});
        end
        checks++;
        if (bus.o_data !== 16'h0000 || bus.o_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: o_data=%h o_count=%0d required 0000/0", bus.o_data, bus.o_count);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.o_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: o_ready=%b required 0 with i_start low", bus.o_ready);
        end
    endtask

    task automatic test_aaaa();
        bus.i_ready = 1'b1;
        bus.i_start = 1'b1;
        frame.delete();
        for (int i = 0; i < NSYM; i++) push_sym(2'b10);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 16'hAAAA || bus.o_done !== 1'b0) begin
            errors++;
            $display("FAIL aaaa_word: vld=%b data=%h done=%b required 1/AAAA/0", bus.o_valid, bus.o_data, bus.o_done);
        end
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b1) begin
            errors++;
            $display("FAIL aaaa_done: vld=%b done=%b required 0/1", bus.o_valid, bus.o_done);
        end
        @(negedge clk);
        checks++;
        if (bus.o_done !== 1'b0) begin
            errors++;
            $display("FAIL aaaa_done_width: done=%b required 0", bus.o_done);
        end
        frame.delete();
    endtask

    task automatic test_1234(input logic hold_ready);
        logic [SIN-1:0] s[NSYM] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0};
        bus.i_ready = ~hold_ready;
        frame.delete();
        for (int i = 0; i < NSYM; i++) begin
            checks++;
            if (bus.o_count !== CW'(i)) begin
                errors++;
                $display("FAIL count_step: o_count=%0d required %0d", bus.o_count, i);
            end
            push_sym(s[i]);
        end
        checks++;
        if (bus.o_count !== 3'd0 || bus.o_valid !== 1'b1 || bus.o_data !== 16'h1234) begin
            errors++;
            $display("FAIL word_1234: cnt=%0d vld=%b data=%h required 0/1/1234", bus.o_count, bus.o_valid, bus.o_data);
        end
        if (hold_ready) begin
            for (int c = 0; c < 5; c++) begin
                bus.i_valid = 1'b1;
                bus.i_data  = SIN'($urandom);
                @(negedge clk);
                checks++;
                if (bus.o_valid !== 1'b1 || bus.o_data !== 16'h1234 || bus.o_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_stable: vld=%b data=%h rdy=%b required 1/1234/0", bus.o_valid, bus.o_data, bus.o_ready);
                end
            end
            bus.i_valid = 1'b0;
            bus.i_ready = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (bus.o_done !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_1234: done=%b vld=%b rdy=%b required 1/0/1", bus.o_done, bus.o_valid, bus.o_ready);
        end
        @(negedge clk);
        frame.delete();
    endtask

    task automatic test_abort();
        bus.i_ready = 1'b1;
        frame.delete();
        for (int i = 0; i < 3; i++) push_sym(2'b11);
        bus.i_start = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 2'b11;
        @(negedge clk);
        checks++;
        if (bus.o_ready !== 1'b0 || bus.o_count !== 3'd0 || bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort: rdy=%b cnt=%0d vld=%b required 0/0/0", bus.o_ready, bus.o_count, bus.o_valid);
        end
        bus.i_valid = 1'b0;
        frame.delete();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_novalid: vld=%b required 0", bus.o_valid);
        end
        bus.i_start = 1'b1;
        for (int i = 0; i < NSYM; i++) push_sym(2'b01);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 16'h5555) begin
            errors++;
            $display("FAIL restart_5555: vld=%b data=%h required 1/5555", bus.o_valid, bus.o_data);
        end
        repeat (2) @(negedge clk);
        frame.delete();
    endtask

    task automatic test_async_reset();
        logic [SOUT-1:0] exp;
        bus.i_start = 1'b1;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_sym(2'b11);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_done} !== 3'b000 || bus.o_count !== 3'd0 || bus.o_data !== 16'h0) begin
            errors++;
            $display("FAIL rst_midword: rdy/vld/done=%b cnt=%0d data=%h required 000/0/0000",
                     {bus.o_ready, bus.o_valid, bus.o_done}, bus.o_count, bus.o_data);
        end
        frame.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_ready = 1'b0;
        for (int i = 0; i < NSYM; i++) push_sym(2'b11);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 16'hFFFF) begin
            errors++;
            $display("FAIL pre_rst_word: vld=%b data=%h required 1/FFFF", bus.o_valid, bus.o_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_done} !== 3'b000 || bus.o_count !== 3'd0 || bus.o_data !== 16'h0) begin
            errors++;
            $display("FAIL rst_output: rdy/vld/done=%b cnt=%0d data=%h required 000/0/0000",
                     {bus.o_ready, bus.o_valid, bus.o_done}, bus.o_count, bus.o_data);
        end
        frame.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        for (int i = 0; i < NSYM; i++) push_sym(SIN'($urandom));
        exp = model_word();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== exp) begin
            errors++;
            $display("FAIL post_rst_word: vld=%b data=%h required 1/%h", bus.o_valid, bus.o_data, exp);
        end
        repeat (2) @(negedge clk);
        frame.delete();
    endtask

    task automatic test_back_to_back();
        logic [SIN-1:0]  syms[$];
        logic [SOUT-1:0] exp_w[3] = '{16'hAAAA, 16'h1234, 16'hFFFF};
        logic [SIN-1:0]  s1234[NSYM] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0};
        int idx = 0, nwords = 0, ndone = 0, last_rise = 0;
        logic prev_valid = 1'b0;
        for (int i = 0; i < NSYM; i++) syms.push_back(2'b10);
        for (int i = 0; i < NSYM; i++) syms.push_back(s1234[i]);
        for (int i = 0; i < NSYM; i++) syms.push_back(2'b11);
        bus.i_start = 1'b1;
        bus.i_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.o_valid === 1'b1 && prev_valid === 1'b0) begin
                checks++;
                if (nwords >= 3 || bus.o_data !== exp_w[nwords % 3]) begin
                    errors++;
                    $display("FAIL b2b_word%0d: data=%h required %h", nwords, bus.o_data, exp_w[nwords % 3]);
                end
                if (nwords > 0) begin
                    checks++;
                    if (cyc - last_rise != NSYM + 1) begin
                        errors++;
                        $display("FAIL b2b_spacing: %0d cycles required %0d", cyc - last_rise, NSYM + 1);
                    end
                end
                last_rise = cyc;
                nwords++;
            end
            if (bus.o_done === 1'b1) ndone++;
            checks++;
            if (bus.o_valid === 1'b1 && bus.o_done === 1'b1) begin
                errors++;
                $display("FAIL b2b_overlap: o_valid=1 o_done=1 at cycle %0d, required never both", cyc);
            end
            prev_valid = bus.o_valid;
            if (idx < syms.size()) begin
                bus.i_valid = 1'b1;
                if (bus.o_ready === 1'b1) begin
                    bus.i_data = syms[idx];
                    idx++;
                end
            end else begin
                bus.i_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (nwords != 3 || ndone != 3) begin
            errors++;
            $display("FAIL b2b_totals: words=%0d done_pulses=%0d required 3/3", nwords, ndone);
        end
        bus.i_valid = 1'b0;
        frame.delete();
    endtask

    task automatic test_random();
        logic [SOUT-1:0] exp;
        bus.i_start = 1'b1;
        for (int w = 0; w < 6; w++) begin
            bus.i_ready = 1'b0;
            frame.delete();
            for (int k = 0; k < NSYM; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.i_data = SIN'($urandom);
                    @(negedge clk);
                end
                checks++;
                if (bus.o_count !== CW'(frame.size())) begin
                    errors++;
                    $display("FAIL rnd_count: o_count=%0d required %0d", bus.o_count, frame.size());
                end
                push_sym(SIN'($urandom_range(0, 3)));
            end
            exp = model_word();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== exp) begin
                errors++;
                $display("FAIL rnd_word%0d: vld=%b data=%h required 1/%h", w, bus.o_valid, bus.o_data, exp);
            end
            bus.i_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.o_done !== 1'b1 || bus.o_valid !== 1'b0) begin
                errors++;
                $display("FAIL rnd_done%0d: done=%b vld=%b required 1/0", w, bus.o_done, bus.o_valid);
            end
            bus.i_ready = 1'b0;
            @(negedge clk);
        end
        frame.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_aaaa();
        test_1234(1'b0);
        test_1234(1'b1);
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/symbol_packer.md
Name: symbol_packer

Overview:
- Opposite direction of the SIPO chunker in the Viterbi datapath: collects SIZE_DATA_IN-bit symbols one per handshake and packs them into one SIZE_DATA_OUT-bit word.
- Sits on the decoder output side. It reassembles decoded or received 2-bit symbols into 16-bit words for downstream storage or compare.
- Frame-gated by i_start. Valid/ready handshake on both sides.

Parameters:
- SIZE_DATA_IN, 2, symbol width in bits.
- SIZE_DATA_OUT, 16, packed word width. Must be an integer multiple of SIZE_DATA_IN.
- NUM_SYM (localparam), SIZE_DATA_OUT/SIZE_DATA_IN = 8, symbols per word.
- CNT_W (localparam), $clog2(NUM_SYM) = 3, symbol counter width.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  frame enable; level-sensitive, held high while packing.
- i_valid  in  1  input symbol valid.
- i_data  in  SIZE_DATA_IN  input symbol.
- o_ready  out  1  block can accept a symbol this cycle.
- o_data  out  SIZE_DATA_OUT  packed word. Stable while o_valid=1.
- o_valid  out  1  packed word available.
- i_ready  in  1  downstream accepts word.
- o_done  out  1  one-cycle pulse, the cycle after a word handshake.
- o_count  out  CNT_W  symbols accepted into the current word.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, shift register=0, o_data=0, o_valid=0, o_ready=0, o_done=0, o_count=0. Reset mid-word discards the partial word; no output is produced for it.
- Input accept: i_valid & o_ready. Output accept: o_valid & i_ready.
- o_ready is combinational from state: 1 only in COLLECT.

States:
- IDLE:
  - o_ready=0.
  - i_start=1 -> COLLECT, count cleared.
- COLLECT:
  - Each input accept does shreg <= {shreg[SIZE_DATA_OUT-SIZE_DATA_IN-1:0], i_data} and count++.
  - The first symbol lands in the MSBs (MSB-first, matching the SIPO emission order).
  - Accept while count==NUM_SYM-1: o_data <= final packed value, o_valid <= 1, count <= 0, next OUTPUT.
  - i_start=0 (checked before accept): abort, discard partial word, count <= 0, next IDLE, no o_valid. The same-cycle symbol is not accepted.
- OUTPUT:
  - o_ready=0, o_valid=1, o_data held.
  - i_start is ignored until the handshake.
  - On output accept: o_valid <= 0, o_done <= 1 for exactly one cycle.
  - Next state COLLECT if i_start=1, else IDLE.
- Latency: o_valid rises on the edge that accepts the last symbol, i.e. visible the cycle after that accept.
- Throughput: with i_valid=i_ready=i_start=1 continuously, one word per NUM_SYM+1 cycles (one bubble cycle in OUTPUT).
- o_count is 0..NUM_SYM-1 and wraps to 0 on word completion; it never reaches NUM_SYM.
- i_valid gaps in COLLECT stall without state change. i_data is ignored when not accepted.
- o_done and o_valid are never high in the same cycle.
- Back-to-back frames: i_start held high continuously chains words with no return to IDLE.

Decomposition:
- Shared package viterbi_pkg holds:
  - typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_OUTPUT} pack_state_t.
  - Default constants SYM_W=2 and WORD_W=16, also used by the SIPO.
- No sub-module. The counter and shift register stay inline; the whole block is about 150 lines.
- Elaboration assertion: SIZE_DATA_OUT % SIZE_DATA_IN == 0 and NUM_SYM >= 2.

Test Plan:
- Reset, then i_start=1, i_ready=1, 8 accepted symbols 2'b10 -> o_valid one cycle after the 8th accept, o_data=16'hAAAA; o_done pulses the following cycle.
- Symbols 0,1,0,2,0,3,1,0 -> o_data=16'h1234. o_count steps 0..7, then 0.
- Word ready with i_ready=0 for 5 cycles -> o_valid and o_data=16'h1234 held stable, o_ready=0, extra i_valid symbols ignored. i_ready=1 -> o_done pulse, back to COLLECT.
- i_start dropped after 3 symbols -> IDLE, no o_valid. Restart with 8 symbols 2'b01 -> o_data=16'h5555, no stale bits.
- i_rst_n pulsed low asynchronously mid-word (4 symbols in) and while in OUTPUT -> all outputs 0 immediately. The next full frame packs correctly.
- Continuous i_valid, i_ready and i_start over 3 words (16'hAAAA, 16'h1234, 16'hFFFF) -> each word appears 9 cycles apart, with exactly 3 o_done pulses.
